// File: rtl/mic4_pkg.sv
// Shared types and constants for the mic4 pulse sequencer.
package mic4_pkg;

  localparam int DEF_CNT_WIDTH = 16;
  localparam int MIN_DLY       = 1;

  typedef enum logic [2:0] {
    IDLE,
    GRST,
    WAIT_A,
    APLS,
    WAIT_D,
    DPLS,
    WAIT_P
  } mic4_seq_state_t;

endpackage

// File: rtl/mic4_seq_timer.sv
// Loadable down-counter shared by the sequencer wait states.
module mic4_seq_timer #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] load_val,
  output logic                 expired
);

  logic [CNT_WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && count != '0)
      count <= count - 1'b1;
  end

  assign expired = (count == '0);

endmodule

// File: rtl/mic4_pulse_sequencer.sv
// grst -> A -> D strobe sequencer for the mic4 control stage.
// Build option: MIC4_SEQ_GRST_EN adds the GRST state and pulse_grst strobe.
module mic4_pulse_sequencer
  import mic4_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [CNT_WIDTH-1:0] dly_grst_a,
  input  logic [CNT_WIDTH-1:0] dly_a_d,
  input  logic [CNT_WIDTH-1:0] period,
  input  logic [CNT_WIDTH-1:0] n_repeat,
  output logic                 pulse_grst,
  output logic                 pulse_a,
  output logic                 pulse_d,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [CNT_WIDTH-1:0] iter_count
);

  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(MIN_DLY);
  localparam logic [CNT_WIDTH-1:0] TWO  = CNT_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0] ALL1 = '1;

  function automatic logic [CNT_WIDTH-1:0] clamp(input logic [CNT_WIDTH-1:0] v);
    return (v < ONE) ? ONE : v;
  endfunction

  mic4_seq_state_t      state_q, state_n;
  logic [CNT_WIDTH-1:0] d1_q, d2_q, p_q, nrep_q, iter_q;
  logic                 tmr_load, tmr_en, tmr_expired;
  logic [CNT_WIDTH-1:0] tmr_val;
  logic                 start_acc, last_iter, done_n, abort_n;
  logic                 pulse_a_q, pulse_d_q, busy_q, done_q, aborted_q;

  assign start_acc = (state_q == IDLE) && start && !stop;
  assign last_iter = (nrep_q != '0) && (iter_q == nrep_q - ONE);

  mic4_seq_timer #(.CNT_WIDTH(CNT_WIDTH)) u_timer (
    .clk      (clk_in),
    .rst      (rst),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  // A wait of N cycles between strobes spends N-1 cycles in the wait state,
  // so N==1 skips it and the timer is loaded with N-2 on entry.
  always_comb begin
    state_n  = state_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    tmr_val  = '0;
    done_n   = 1'b0;
    abort_n  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_acc) begin
`ifdef MIC4_SEQ_GRST_EN
          state_n = GRST;
`else
          state_n  = WAIT_A;
          tmr_load = 1'b1;
          tmr_val  = clamp(dly_grst_a) - ONE;
`endif
        end
      end
      GRST: begin
        if (d1_q == ONE) begin
          state_n = APLS;
        end else begin
          state_n  = WAIT_A;
          tmr_load = 1'b1;
          tmr_val  = d1_q - TWO;
        end
      end
      WAIT_A: begin
        tmr_en = 1'b1;
        if (tmr_expired) state_n = APLS;
      end
      APLS: begin
        if (d2_q == ONE) begin
          state_n = DPLS;
        end else begin
          state_n  = WAIT_D;
          tmr_load = 1'b1;
          tmr_val  = d2_q - TWO;
        end
      end
      WAIT_D: begin
        tmr_en = 1'b1;
        if (tmr_expired) state_n = DPLS;
      end
      DPLS: begin
        if (last_iter) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else if (p_q == ONE) begin
`ifdef MIC4_SEQ_GRST_EN
          state_n = GRST;
`else
          state_n  = WAIT_A;
          tmr_load = 1'b1;
          tmr_val  = d1_q - ONE;
`endif
        end else begin
          state_n  = WAIT_P;
          tmr_load = 1'b1;
          tmr_val  = p_q - TWO;
        end
      end
      WAIT_P: begin
        tmr_en = 1'b1;
        if (tmr_expired) begin
`ifdef MIC4_SEQ_GRST_EN
          state_n = GRST;
`else
          // Without GRST the full D1 wait follows the period.
          state_n  = WAIT_A;
          tmr_load = 1'b1;
          tmr_val  = d1_q - ONE;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
    if (stop && state_q != IDLE) begin
      state_n  = IDLE;
      tmr_load = 1'b0;
      done_n   = 1'b1;
      abort_n  = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      d1_q      <= ONE;
      d2_q      <= ONE;
      p_q       <= ONE;
      nrep_q    <= '0;
      iter_q    <= '0;
      pulse_a_q <= 1'b0;
      pulse_d_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      pulse_a_q <= (state_n == APLS);
      pulse_d_q <= (state_n == DPLS);
      busy_q    <= (state_n != IDLE);
      done_q    <= done_n;
      if (start_acc) begin
        d1_q   <= clamp(dly_grst_a);
        d2_q   <= clamp(dly_a_d);
        p_q    <= clamp(period);
        nrep_q <= n_repeat;
      end
      if (start_acc)
        aborted_q <= 1'b0;
      else if (abort_n)
        aborted_q <= 1'b1;
      if (start_acc)
        iter_q <= '0;
      else if (state_q == DPLS && iter_q != ALL1)
        iter_q <= iter_q + ONE;
    end
  end

`ifdef MIC4_SEQ_GRST_EN
  logic pulse_grst_q;
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) pulse_grst_q <= 1'b0;
    else     pulse_grst_q <= (state_n == GRST);
  end
  assign pulse_grst = pulse_grst_q;
`else
  assign pulse_grst = 1'b0;
`endif

  assign pulse_a    = pulse_a_q;
  assign pulse_d    = pulse_d_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_mic4_pulse_sequencer.sv
// Scoreboard bench for mic4_pulse_sequencer; follows MIC4_SEQ_GRST_EN if defined.
module tb_mic4_pulse_sequencer;

`ifdef MIC4_SEQ_GRST_EN
  localparam bit GRST_EN = 1'b1;
`else
  localparam bit GRST_EN = 1'b0;
`endif

  typedef struct packed {
    int          t;
    logic [3:0]  ev;    // {grst, a, d, done}
    logic        busy;
    logic        abrt;
    logic [15:0] iter;
  } evt_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0;
  logic [15:0] dly_grst_a = '0, dly_a_d = '0, period = '0, n_repeat = '0;
  logic        pulse_grst, pulse_a, pulse_d, busy, done, aborted;
  logic [15:0] iter_count;

  int   cyc = 0, t0 = 0;
  int   n_chk = 0, n_pass = 0;
  int   obs_rd = 0;
  evt_t exp_q[$];
  evt_t obs_q[$];
  evt_t mon_e;

  mic4_pulse_sequencer #(.CNT_WIDTH(16)) dut (
    .clk_in(clk), .rst(rst), .start(start), .stop(stop),
    .dly_grst_a(dly_grst_a), .dly_a_d(dly_a_d), .period(period), .n_repeat(n_repeat),
    .pulse_grst(pulse_grst), .pulse_a(pulse_a), .pulse_d(pulse_d),
    .busy(busy), .done(done), .aborted(aborted), .iter_count(iter_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if ({pulse_grst, pulse_a, pulse_d, done} != 4'b0000) begin
      mon_e.t    = cyc - t0;
      mon_e.ev   = {pulse_grst, pulse_a, pulse_d, done};
      mon_e.busy = busy;
      mon_e.abrt = aborted;
      mon_e.iter = iter_count;
      obs_q.push_back(mon_e);
    end
  end

  task automatic push_ev(int t, logic [3:0] ev, logic b, logic ab, int it);
    evt_t e;
    e.t = t; e.ev = ev; e.busy = b; e.abrt = ab; e.iter = 16'(it);
    exp_q.push_back(e);
  endtask

  // Reference timeline: s is the (possibly virtual) grst cycle of each iteration.
  task automatic push_model(int d1, int d2, int p, int n, int stop_t);
    int dd1, dd2, pp, s, ta, td;
    dd1 = (d1 == 0) ? 1 : d1;
    dd2 = (d2 == 0) ? 1 : d2;
    pp  = (p == 0) ? 1 : p;
    s   = 1;
    for (int k = 0; k < 200; k++) begin
      ta = s + dd1;
      td = ta + dd2;
      if (GRST_EN) begin
        if (stop_t >= 0 && s > stop_t) begin push_ev(stop_t + 1, 4'b0001, 0, 1, k); return; end
        push_ev(s, 4'b1000, 1, 0, k);
      end
      if (stop_t >= 0 && ta > stop_t) begin push_ev(stop_t + 1, 4'b0001, 0, 1, k); return; end
      push_ev(ta, 4'b0100, 1, 0, k);
      if (stop_t >= 0 && td > stop_t) begin push_ev(stop_t + 1, 4'b0001, 0, 1, k); return; end
      push_ev(td, 4'b0010, 1, 0, k);
      if (n != 0 && k + 1 == n) begin push_ev(td + 1, 4'b0001, 0, 0, n); return; end
      s = td + pp;
    end
  endtask

  task automatic kick(int d1, int d2, int p, int n);
    @(negedge clk);
    dly_grst_a = 16'(d1); dly_a_d = 16'(d2); period = 16'(p); n_repeat = 16'(n);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_rel(int r);
    while (cyc - t0 < r) @(negedge clk);
  endtask

  task automatic test_reset;
    int bad;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (pulse_grst !== 1'b0) $display("FAIL reset_grst: got %b want 0", pulse_grst); else n_pass++;
    n_chk++; if (pulse_a !== 1'b0) $display("FAIL reset_a: got %b want 0", pulse_a); else n_pass++;
    n_chk++; if (pulse_d !== 1'b0) $display("FAIL reset_d: got %b want 0", pulse_d); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_chk++; if (aborted !== 1'b0) $display("FAIL reset_aborted: got %b want 0", aborted); else n_pass++;
    n_chk++; if (iter_count !== 16'd0) $display("FAIL reset_iter: got %0d want 0", iter_count); else n_pass++;
    rst = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if ({pulse_grst, pulse_a, pulse_d, busy, done, aborted, iter_count} !== '0) bad++;
    end
    n_chk++; if (bad != 0) $display("FAIL idle_quiet: got %0d active cycles want 0", bad); else n_pass++;
  endtask

  task automatic test_single;
    evt_t e, o;
    kick(5, 10, 20, 1);
    push_model(5, 10, 20, 1, -1);
    wait_rel(40);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_chk++;
      if (obs_rd >= obs_q.size()) $display("FAIL single: missing event, want t=%0d ev=%b", e.t, e.ev);
      else begin
        o = obs_q[obs_rd]; obs_rd++;
        if (o !== e) $display("FAIL single: got t=%0d ev=%b busy=%b ab=%b it=%0d want t=%0d ev=%b busy=%b ab=%b it=%0d",
                              o.t, o.ev, o.busy, o.abrt, o.iter, e.t, e.ev, e.busy, e.abrt, e.iter);
        else n_pass++;
      end
    end
    n_chk++; if (obs_rd != obs_q.size()) $display("FAIL single_extra: got %0d extra events want 0", obs_q.size() - obs_rd); else n_pass++;
    obs_rd = obs_q.size();
  endtask

  task automatic test_repeat;
    evt_t e, o;
    kick(5, 10, 20, 3);
    push_model(5, 10, 20, 3, -1);
    wait_rel(110);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_chk++;
      if (obs_rd >= obs_q.size()) $display("FAIL repeat: missing event, want t=%0d ev=%b", e.t, e.ev);
      else begin
        o = obs_q[obs_rd]; obs_rd++;
        if (o !== e) $display("FAIL repeat: got t=%0d ev=%b busy=%b ab=%b it=%0d want t=%0d ev=%b busy=%b ab=%b it=%0d",
                              o.t, o.ev, o.busy, o.abrt, o.iter, e.t, e.ev, e.busy, e.abrt, e.iter);
        else n_pass++;
      end
    end
    n_chk++; if (obs_rd != obs_q.size()) $display("FAIL repeat_extra: got %0d extra events want 0", obs_q.size() - obs_rd); else n_pass++;
    obs_rd = obs_q.size();
  endtask

  task automatic test_zero_delays;
    evt_t e, o;
    kick(0, 0, 0, 2);
    push_model(0, 0, 0, 2, -1);
    wait_rel(20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_chk++;
      if (obs_rd >= obs_q.size()) $display("FAIL zero: missing event, want t=%0d ev=%b", e.t, e.ev);
      else begin
        o = obs_q[obs_rd]; obs_rd++;
        if (o !== e) $display("FAIL zero: got t=%0d ev=%b busy=%b ab=%b it=%0d want t=%0d ev=%b busy=%b ab=%b it=%0d",
                              o.t, o.ev, o.busy, o.abrt, o.iter, e.t, e.ev, e.busy, e.abrt, e.iter);
        else n_pass++;
      end
    end
    n_chk++; if (obs_rd != obs_q.size()) $display("FAIL zero_extra: got %0d extra events want 0", obs_q.size() - obs_rd); else n_pass++;
    obs_rd = obs_q.size();
  endtask

  task automatic test_abort;
    evt_t e, o;
    kick(5, 10, 20, 0);
    push_model(5, 10, 20, 0, 40);
    // Start while busy and input changes after start must both be ignored.
    wait_rel(10);
    dly_grst_a = 16'd1; dly_a_d = 16'd1; period = 16'd1; n_repeat = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_rel(20);
    dly_grst_a = 16'd2; dly_a_d = 16'd3; period = 16'd4;
    wait_rel(40);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_rel(70);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_chk++;
      if (obs_rd >= obs_q.size()) $display("FAIL abort: missing event, want t=%0d ev=%b", e.t, e.ev);
      else begin
        o = obs_q[obs_rd]; obs_rd++;
        if (o !== e) $display("FAIL abort: got t=%0d ev=%b busy=%b ab=%b it=%0d want t=%0d ev=%b busy=%b ab=%b it=%0d",
                              o.t, o.ev, o.busy, o.abrt, o.iter, e.t, e.ev, e.busy, e.abrt, e.iter);
        else n_pass++;
      end
    end
    n_chk++; if (obs_rd != obs_q.size()) $display("FAIL abort_extra: got %0d extra events want 0", obs_q.size() - obs_rd); else n_pass++;
    obs_rd = obs_q.size();
    n_chk++; if (aborted !== 1'b1) $display("FAIL abort_hold: got aborted=%b want 1", aborted); else n_pass++;
  endtask

  task automatic test_start_stop_same;
    @(negedge clk);
    dly_grst_a = 16'd2; dly_a_d = 16'd2; period = 16'd2; n_repeat = 16'd1;
    start = 1'b1; stop = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    wait_rel(30);
    n_chk++; if (obs_rd != obs_q.size()) $display("FAIL start_stop_same: got %0d events want 0", obs_q.size() - obs_rd); else n_pass++;
    obs_rd = obs_q.size();
    n_chk++; if ({busy, aborted} !== 2'b01) $display("FAIL start_stop_state: got busy/aborted=%b want 01", {busy, aborted}); else n_pass++;
  endtask

  task automatic test_reset_mid;
    evt_t e, o;
    kick(5, 10, 20, 0);
    wait_rel(10);
    #1 rst = 1'b1;
    #1;
    n_chk++;
    if ({pulse_grst, pulse_a, pulse_d, busy, done, aborted, iter_count} !== '0)
      $display("FAIL reset_mid_clear: got busy=%b done=%b ab=%b it=%0d want all 0", busy, done, aborted, iter_count);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    obs_rd = obs_q.size();
    repeat (30) @(negedge clk);
    n_chk++; if (obs_rd != obs_q.size()) $display("FAIL reset_mid_nodone: got %0d events want 0", obs_q.size() - obs_rd); else n_pass++;
    obs_rd = obs_q.size();
    kick(3, 4, 5, 1);
    push_model(3, 4, 5, 1, -1);
    wait_rel(25);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_chk++;
      if (obs_rd >= obs_q.size()) $display("FAIL reset_mid_restart: missing event, want t=%0d ev=%b", e.t, e.ev);
      else begin
        o = obs_q[obs_rd]; obs_rd++;
        if (o !== e) $display("FAIL reset_mid_restart: got t=%0d ev=%b busy=%b ab=%b it=%0d want t=%0d ev=%b busy=%b ab=%b it=%0d",
                              o.t, o.ev, o.busy, o.abrt, o.iter, e.t, e.ev, e.busy, e.abrt, e.iter);
        else n_pass++;
      end
    end
    n_chk++; if (obs_rd != obs_q.size()) $display("FAIL reset_mid_extra: got %0d extra events want 0", obs_q.size() - obs_rd); else n_pass++;
    obs_rd = obs_q.size();
  endtask

  initial begin
    test_reset;
    test_single;
    test_repeat;
    test_zero_delays;
    test_abort;
    test_start_stop_same;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
